// File: rtl/cache_defs.sv
// Shared definitions for the cache miss-fill engine: FSM state encoding and
// geometry helpers for beat count and line address composition.
package cache_defs;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LRU_RD   = 3'd1,
      S_INVAL    = 3'd2,
      S_MEM_REQ  = 3'd3,
      S_MEM_RESP = 3'd4,
      S_WRITE    = 3'd5
   } fill_state_e;

   function automatic int calc_num_beats(input int line_bytes, input int mem_data_width);
      return (line_bytes * 8) / mem_data_width;
   endfunction

   function automatic int calc_offset_bits(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   // Byte address = {tag, set index, line offset}.
   function automatic int calc_addr_width(input int tag_width, input int num_sets,
                                          input int line_bytes);
      return tag_width + $clog2(num_sets) + calc_offset_bits(line_bytes);
   endfunction

endpackage

// File: rtl/cache_line_assembler.sv
// Collects memory response beats into one cache line; beat 0 lands in the
// lowest bits. The beat counter wraps to 0 after the final beat.
module cache_line_assembler #(
   parameter int MEM_DATA_WIDTH  = 128,
   parameter int NUM_BEATS       = 4,
   parameter int CACHE_LINE_BITS = MEM_DATA_WIDTH * NUM_BEATS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       beat_en,
   input  logic [MEM_DATA_WIDTH-1:0]  beat_data,
   output logic                       last_beat,
   output logic [CACHE_LINE_BITS-1:0] line
);

   localparam int               CNT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

   logic [CNT_W-1:0]           cnt_q;
   logic [CACHE_LINE_BITS-1:0] line_q;

   assign last_beat = beat_en && (cnt_q == LAST_CNT);
   assign line      = line_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (beat_en) begin
         cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // NOTE: the line buffer is a wide datapath register and is deliberately not
   // reset; every bit is rewritten by a full fill before it is ever consumed.
   always_ff @(posedge clk) begin
      if (beat_en) begin
         line_q[int'(cnt_q) * MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= beat_data;
      end
   end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-fill engine: picks an LRU victim, invalidates it, fetches the line from
// memory beat by beat, then writes data and a valid tag in a single cycle.
module cache_fill_ctrl
   import cache_defs::*;
#(
   parameter int NUM_WAYS         = 4,
   parameter int NUM_SETS         = 16,
   parameter int CACHE_TAG_WIDTH  = 22,
   parameter int CACHE_LINE_BYTES = 64,
   parameter int MEM_DATA_WIDTH   = 128,
   parameter int NUM_WAYS_LOG     = $clog2(NUM_WAYS),
   parameter int NUM_SETS_LOG     = $clog2(NUM_SETS),
   parameter int CACHE_LINE_BITS  = CACHE_LINE_BYTES * 8,
   parameter int NUM_BEATS        = calc_num_beats(CACHE_LINE_BYTES, MEM_DATA_WIDTH),
   parameter int ADDR_WIDTH       = calc_addr_width(CACHE_TAG_WIDTH, NUM_SETS, CACHE_LINE_BYTES)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       miss_valid,
   output logic                       miss_ready,
   input  logic [CACHE_TAG_WIDTH-1:0] miss_tag,
   input  logic [NUM_SETS_LOG-1:0]    miss_set_idx,
   output logic                       mem_req_valid,
   input  logic                       mem_req_ready,
   output logic [ADDR_WIDTH-1:0]      mem_req_addr,
   input  logic                       mem_resp_valid,
   input  logic [MEM_DATA_WIDTH-1:0]  mem_resp_data,
   output logic                       lru_fill_en,
   output logic [NUM_SETS_LOG-1:0]    lru_fill_set,
   input  logic [NUM_WAYS_LOG-1:0]    lru_fill_way_idx,
   output logic                       update_tag_en,
   output logic [NUM_WAYS_LOG-1:0]    update_tag_way_idx,
   output logic [NUM_SETS_LOG-1:0]    update_tag_set_idx,
   output logic [CACHE_TAG_WIDTH-1:0] update_tag,
   output logic                       update_tag_valid,
   output logic                       update_data_en,
   output logic [NUM_WAYS_LOG-1:0]    update_data_way_idx,
   output logic [NUM_SETS_LOG-1:0]    update_data_set_idx,
   output logic [CACHE_LINE_BITS-1:0] update_data,
   output logic                       fill_done,
   output logic [NUM_WAYS_LOG-1:0]    fill_done_way_idx
);

   localparam int OFFSET_BITS = ADDR_WIDTH - CACHE_TAG_WIDTH - NUM_SETS_LOG;

   fill_state_e                state_q, state_d;
   logic [CACHE_TAG_WIDTH-1:0] tag_q;
   logic [NUM_SETS_LOG-1:0]    set_q;
   logic [NUM_WAYS_LOG-1:0]    way_q;
   logic                       beat_en;
   logic                       last_beat;
   logic [CACHE_LINE_BITS-1:0] line;

   // Beats outside MEM_RESP (including stragglers after a reset) are dropped.
   assign beat_en = (state_q == S_MEM_RESP) && mem_resp_valid;

   cache_line_assembler #(
      .MEM_DATA_WIDTH  (MEM_DATA_WIDTH),
      .NUM_BEATS       (NUM_BEATS),
      .CACHE_LINE_BITS (CACHE_LINE_BITS)
   ) u_assembler (
      .clk       (clk),
      .rst_n     (rst_n),
      .beat_en   (beat_en),
      .beat_data (mem_resp_data),
      .last_beat (last_beat),
      .line      (line)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_q <= '0;
         set_q <= '0;
         way_q <= '0;
      end else begin
         if (state_q == S_IDLE && miss_valid) begin
            tag_q <= miss_tag;
            set_q <= miss_set_idx;
         end
         if (state_q == S_INVAL) begin
            way_q <= lru_fill_way_idx;
         end
      end
   end

   // NOTE: next state defaults to the current state so no path leaves it unassigned.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (miss_valid) state_d = S_LRU_RD;
         S_LRU_RD:   state_d = S_INVAL;
         S_INVAL:    state_d = S_MEM_REQ;
         S_MEM_REQ:  if (mem_req_ready) state_d = S_MEM_RESP;
         S_MEM_RESP: if (last_beat) state_d = S_WRITE;
         S_WRITE:    state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      miss_ready          = 1'b0;
      mem_req_valid       = 1'b0;
      mem_req_addr        = '0;
      lru_fill_en         = 1'b0;
      lru_fill_set        = '0;
      update_tag_en       = 1'b0;
      update_tag_way_idx  = '0;
      update_tag_set_idx  = '0;
      update_tag          = '0;
      update_tag_valid    = 1'b0;
      update_data_en      = 1'b0;
      update_data_way_idx = '0;
      update_data_set_idx = '0;
      update_data         = '0;
      fill_done           = 1'b0;
      fill_done_way_idx   = '0;
      case (state_q)
         S_IDLE: begin
            miss_ready = 1'b1;
         end
         S_LRU_RD: begin
            lru_fill_en  = 1'b1;
            lru_fill_set = set_q;
         end
         S_INVAL: begin
            // The LRU answer is only present this cycle, so the invalidate
            // forwards it while way_q captures it for the final write.
            update_tag_en      = 1'b1;
            update_tag_way_idx = lru_fill_way_idx;
            update_tag_set_idx = set_q;
            update_tag         = tag_q;
         end
         S_MEM_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {tag_q, set_q, {OFFSET_BITS{1'b0}}};
         end
         S_WRITE: begin
            update_data_en      = 1'b1;
            update_data_way_idx = way_q;
            update_data_set_idx = set_q;
            update_data         = line;
            update_tag_en       = 1'b1;
            update_tag_way_idx  = way_q;
            update_tag_set_idx  = set_q;
            update_tag          = tag_q;
            update_tag_valid    = 1'b1;
            fill_done           = 1'b1;
            fill_done_way_idx   = way_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a behavioural LRU responder, a memory
// driver inside the fill task, and a negedge monitor that records write events.
module tb_cache_fill_ctrl;

   localparam int TAG_W     = 22;
   localparam int SET_W     = 4;
   localparam int WAY_W     = 2;
   localparam int MEM_W     = 128;
   localparam int LINE_W    = 512;
   localparam int ADDR_W    = 32;
   localparam int NUM_BEATS = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              miss_valid;
   logic              miss_ready;
   logic [TAG_W-1:0]  miss_tag;
   logic [SET_W-1:0]  miss_set_idx;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_resp_valid;
   logic [MEM_W-1:0]  mem_resp_data;
   logic              lru_fill_en;
   logic [SET_W-1:0]  lru_fill_set;
   logic [WAY_W-1:0]  lru_fill_way_idx = '0;
   logic              update_tag_en;
   logic [WAY_W-1:0]  update_tag_way_idx;
   logic [SET_W-1:0]  update_tag_set_idx;
   logic [TAG_W-1:0]  update_tag;
   logic              update_tag_valid;
   logic              update_data_en;
   logic [WAY_W-1:0]  update_data_way_idx;
   logic [SET_W-1:0]  update_data_set_idx;
   logic [LINE_W-1:0] update_data;
   logic              fill_done;
   logic [WAY_W-1:0]  fill_done_way_idx;

   cache_fill_ctrl dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .miss_valid          (miss_valid),
      .miss_ready          (miss_ready),
      .miss_tag            (miss_tag),
      .miss_set_idx        (miss_set_idx),
      .mem_req_valid       (mem_req_valid),
      .mem_req_ready       (mem_req_ready),
      .mem_req_addr        (mem_req_addr),
      .mem_resp_valid      (mem_resp_valid),
      .mem_resp_data       (mem_resp_data),
      .lru_fill_en         (lru_fill_en),
      .lru_fill_set        (lru_fill_set),
      .lru_fill_way_idx    (lru_fill_way_idx),
      .update_tag_en       (update_tag_en),
      .update_tag_way_idx  (update_tag_way_idx),
      .update_tag_set_idx  (update_tag_set_idx),
      .update_tag          (update_tag),
      .update_tag_valid    (update_tag_valid),
      .update_data_en      (update_data_en),
      .update_data_way_idx (update_data_way_idx),
      .update_data_set_idx (update_data_set_idx),
      .update_data         (update_data),
      .fill_done           (fill_done),
      .fill_done_way_idx   (fill_done_way_idx)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [WAY_W-1:0] lru_victim = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // LRU model: victim appears the cycle after a query.
   always @(posedge clk) begin
      logic q;
      q = lru_fill_en;
      #1;
      if (q) lru_fill_way_idx = lru_victim;
   end

   // Monitor state
   int inv_cnt = 0, inv_cyc = -1;
   logic [WAY_W-1:0] inv_way; logic [SET_W-1:0] inv_set; logic [TAG_W-1:0] inv_tag;
   int wr_cnt = 0, wr_cyc = -1, vtag_cnt = 0;
   logic [LINE_W-1:0] wr_line;
   logic [WAY_W-1:0] wr_way, wr_tag_way; logic [SET_W-1:0] wr_set, wr_tag_set;
   logic [TAG_W-1:0] wr_tag; logic wr_tag_en, wr_tag_valid;
   int done_cnt = 0, done_cyc = -1; logic [WAY_W-1:0] done_way;
   int req_cnt = 0, req_cyc = -1, req_valid_cycles = 0, addr_unstable = 0;
   logic [ADDR_W-1:0] req_addr, prev_addr;
   logic prev_valid = 1'b0, prev_acc = 1'b0;
   int lru_cyc = -1; logic [SET_W-1:0] lru_set;
   int resp_cyc = -1, ready_cnt = 0, zero_viol = 0;

   always @(negedge clk) begin
      if (miss_ready === 1'b1) ready_cnt++;
      if (lru_fill_en) begin lru_cyc = cyc; lru_set = lru_fill_set; end
      if (update_tag_en && !update_tag_valid) begin
         inv_cnt++; inv_cyc = cyc;
         inv_way = update_tag_way_idx; inv_set = update_tag_set_idx; inv_tag = update_tag;
      end
      if (update_tag_en && update_tag_valid) vtag_cnt++;
      if (update_data_en) begin
         wr_cnt++; wr_cyc = cyc; wr_line = update_data;
         wr_way = update_data_way_idx; wr_set = update_data_set_idx;
         wr_tag_en = update_tag_en; wr_tag_valid = update_tag_valid;
         wr_tag_way = update_tag_way_idx; wr_tag_set = update_tag_set_idx; wr_tag = update_tag;
      end
      if (fill_done) begin done_cnt++; done_cyc = cyc; done_way = fill_done_way_idx; end
      if (mem_req_valid) begin
         req_valid_cycles++;
         if (prev_valid && !prev_acc && mem_req_addr !== prev_addr) addr_unstable++;
         if (mem_req_ready) begin req_cnt++; req_cyc = cyc; req_addr = mem_req_addr; end
      end
      prev_valid = mem_req_valid; prev_acc = mem_req_valid && mem_req_ready; prev_addr = mem_req_addr;
      if (mem_resp_valid) resp_cyc = cyc;
      if (!update_tag_en && {update_tag_way_idx, update_tag_set_idx, update_tag, update_tag_valid} != '0) zero_viol++;
      if (!update_data_en && {update_data_way_idx, update_data_set_idx, update_data} != '0) zero_viol++;
      if (!fill_done && fill_done_way_idx != '0) zero_viol++;
      if (!mem_req_valid && mem_req_addr != '0) zero_viol++;
      if (!lru_fill_en && lru_fill_set != '0) zero_viol++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [MEM_W-1:0] beat_val(input logic [31:0] seed, input int k);
      return {seed, 32'hDEADBEEF, ~seed, 24'h0, 8'(k)};
   endfunction

   function automatic logic [LINE_W-1:0] exp_line(input logic [31:0] seed);
      return {beat_val(seed, 3), beat_val(seed, 2), beat_val(seed, 1), beat_val(seed, 0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one complete fill starting in IDLE; returns the acceptance cycle.
   task automatic run_fill(input logic [TAG_W-1:0] t, input logic [SET_W-1:0] s,
                           input logic [WAY_W-1:0] v, input int stall, input int gap,
                           input logic [31:0] seed, input logic hold2,
                           input logic [TAG_W-1:0] t2, input logic [SET_W-1:0] s2,
                           output int start);
      int waited;
      lru_victim    = v;
      miss_tag      = t;
      miss_set_idx  = s;
      miss_valid    = 1'b1;
      mem_req_ready = (stall == 0);
      start         = cyc;
      tick();
      if (hold2) begin
         miss_tag     = t2;
         miss_set_idx = s2;
      end else begin
         miss_valid = 1'b0;
      end
      waited = 0;
      while (!mem_req_valid && waited < 20) begin
         tick();
         waited++;
      end
      if (!mem_req_valid) begin
         n_cmp++; n_err++;
         $display("FAIL req_timeout: mem_req_valid not seen within 20 cycles");
      end
      repeat (stall) tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      for (int k = 0; k < NUM_BEATS; k++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = beat_val(seed, k);
         tick();
         mem_resp_valid = 1'b0;
         mem_resp_data  = '0;
         if (k < NUM_BEATS - 1) repeat (gap) tick();
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; miss_valid = 1'b0; miss_tag = '0; miss_set_idx = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      repeat (2) tick();
      n_cmp++;
      if (miss_ready !== 1'b1) begin n_err++; $display("FAIL reset_miss_ready: got %b want 1", miss_ready); end
      n_cmp++;
      if ({mem_req_valid, mem_req_addr, lru_fill_en, lru_fill_set, update_tag_en, update_tag_valid,
           update_data_en, update_data, fill_done, fill_done_way_idx} !== '0) begin
         n_err++; $display("FAIL reset_outputs: some output nonzero during reset");
      end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if ({miss_ready, mem_req_valid, lru_fill_en, update_tag_en, update_data_en, fill_done} !== 6'b100000) begin
         n_err++; $display("FAIL reset_release: got %b want 100000",
                           {miss_ready, mem_req_valid, lru_fill_en, update_tag_en, update_data_en, fill_done});
      end
   endtask

   task automatic test_basic_fill();
      int st, r0, w0, d0;
      r0 = ready_cnt; w0 = wr_cnt; d0 = done_cnt;
      run_fill(22'h2A5F1, 4'd3, 2'd2, 0, 0, 32'h0000_0000, 1'b0, '0, '0, st);
      n_cmp++;
      if (lru_cyc !== st + 1 || lru_set !== 4'd3) begin
         n_err++; $display("FAIL basic_lru: cyc %0d set %0d want cyc %0d set 3", lru_cyc - st, lru_set, 1);
      end
      n_cmp++;
      if (inv_cyc !== st + 2 || {inv_way, inv_set, inv_tag} !== {2'd2, 4'd3, 22'h2A5F1}) begin
         n_err++; $display("FAIL basic_inval: cyc %0d way %0d set %0d tag %h want cyc 2 way 2 set 3 tag 2a5f1",
                           inv_cyc - st, inv_way, inv_set, inv_tag);
      end
      n_cmp++;
      if (req_cyc !== st + 3 || req_addr !== 32'h0A97C4C0) begin
         n_err++; $display("FAIL basic_req: cyc %0d addr %h want cyc 3 addr 0a97c4c0", req_cyc - st, req_addr);
      end
      n_cmp++;
      if (wr_cnt - w0 !== 1 || wr_cyc !== st + 8 || wr_line !== exp_line(32'h0)) begin
         n_err++; $display("FAIL basic_data: cnt %0d cyc %0d line %h want 1 write at cyc 8 line %h",
                           wr_cnt - w0, wr_cyc - st, wr_line, exp_line(32'h0));
      end
      n_cmp++;
      if ({wr_way, wr_set, wr_tag_en, wr_tag_valid, wr_tag_way, wr_tag_set, wr_tag} !==
          {2'd2, 4'd3, 1'b1, 1'b1, 2'd2, 4'd3, 22'h2A5F1}) begin
         n_err++; $display("FAIL basic_final_tag: way %0d set %0d tag_en %b valid %b tway %0d tset %0d tag %h",
                           wr_way, wr_set, wr_tag_en, wr_tag_valid, wr_tag_way, wr_tag_set, wr_tag);
      end
      n_cmp++;
      if (done_cnt - d0 !== 1 || done_cyc !== st + 8 || done_way !== 2'd2) begin
         n_err++; $display("FAIL basic_done: cnt %0d cyc %0d way %0d want 1 at cyc 8 way 2",
                           done_cnt - d0, done_cyc - st, done_way);
      end
      n_cmp++;
      if (miss_ready !== 1'b1 || cyc !== st + 9 || ready_cnt - r0 !== 1) begin
         n_err++; $display("FAIL basic_ready_again: ready %b at cyc %0d busy-ready count %0d want 1 at 9 and 1",
                           miss_ready, cyc - st, ready_cnt - r0);
      end
   endtask

   task automatic test_backpressure();
      int st, q0, v0, u0;
      q0 = req_cnt; v0 = req_valid_cycles; u0 = addr_unstable;
      run_fill(22'h155AA, 4'd7, 2'd1, 5, 0, 32'hCAFE_0001, 1'b0, '0, '0, st);
      n_cmp++;
      if (req_cnt - q0 !== 1 || req_valid_cycles - v0 !== 6 || addr_unstable - u0 !== 0) begin
         n_err++; $display("FAIL bp_request: accepted %0d valid cycles %0d unstable %0d want 1 6 0",
                           req_cnt - q0, req_valid_cycles - v0, addr_unstable - u0);
      end
      n_cmp++;
      if (req_addr !== {22'h155AA, 4'd7, 6'd0} || req_cyc !== st + 8) begin
         n_err++; $display("FAIL bp_addr: addr %h cyc %0d want %h cyc 8", req_addr, req_cyc - st,
                           {22'h155AA, 4'd7, 6'd0});
      end
      n_cmp++;
      if (done_cyc !== st + 13 || wr_line !== exp_line(32'hCAFE_0001)) begin
         n_err++; $display("FAIL bp_fill: done cyc %0d want 13, line %h want %h", done_cyc - st, wr_line,
                           exp_line(32'hCAFE_0001));
      end
   endtask

   task automatic test_beat_gaps();
      int st;
      run_fill(22'h0F0F0, 4'd10, 2'd0, 0, 2, 32'h1357_9BDF, 1'b0, '0, '0, st);
      n_cmp++;
      if (wr_line !== exp_line(32'h1357_9BDF)) begin
         n_err++; $display("FAIL gap_line: got %h want %h", wr_line, exp_line(32'h1357_9BDF));
      end
      n_cmp++;
      if (wr_cyc !== resp_cyc + 1 || done_cyc !== st + 14) begin
         n_err++; $display("FAIL gap_write_timing: write cyc %0d last beat cyc %0d want %0d and %0d",
                           wr_cyc - st, resp_cyc - st, 14, 13);
      end
   endtask

   task automatic test_back_to_back_busy();
      int st, r0;
      r0 = ready_cnt;
      run_fill(22'h2222, 4'd1, 2'd3, 0, 0, 32'hB0B0_0002, 1'b1, 22'h1234, 4'd9, st);
      n_cmp++;
      if (ready_cnt - r0 !== 1) begin
         n_err++; $display("FAIL busy_ready_low: miss_ready high %0d cycles during fill want 1", ready_cnt - r0);
      end
      n_cmp++;
      if (wr_line !== exp_line(32'hB0B0_0002) || wr_tag !== 22'h2222 || wr_set !== 4'd1) begin
         n_err++; $display("FAIL busy_first_fill: tag %h set %0d want 2222 set 1", wr_tag, wr_set);
      end
      n_cmp++;
      if (miss_ready !== 1'b1 || cyc !== st + 9) begin
         n_err++; $display("FAIL busy_accept: ready %b at cyc %0d want 1 at 9", miss_ready, cyc - st);
      end
      tick();
      miss_valid = 1'b0;
      n_cmp++;
      if (lru_fill_en !== 1'b1 || lru_fill_set !== 4'd9) begin
         n_err++; $display("FAIL busy_second_lru: en %b set %0d want 1 set 9", lru_fill_en, lru_fill_set);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_fill();
      int st, w0, d0, t0;
      w0 = wr_cnt; d0 = done_cnt; t0 = vtag_cnt;
      lru_victim = 2'd1; miss_tag = 22'h0ABCD; miss_set_idx = 4'd5; miss_valid = 1'b1;
      mem_req_ready = 1'b1; st = cyc;
      tick();
      miss_valid = 1'b0;
      tick(); tick();
      n_cmp++;
      if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid_req: got %b want 1", mem_req_valid); end
      tick();
      mem_req_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mem_resp_valid = 1'b1; mem_resp_data = beat_val(32'h7777_7777, k);
         tick();
      end
      mem_resp_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++;
      if (miss_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", miss_ready); end
      for (int k = 2; k < NUM_BEATS; k++) begin
         mem_resp_valid = 1'b1; mem_resp_data = beat_val(32'h7777_7777, k);
         tick();
      end
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      tick(); tick();
      n_cmp++;
      if (wr_cnt - w0 !== 0 || done_cnt - d0 !== 0 || vtag_cnt - t0 !== 0) begin
         n_err++; $display("FAIL rst_mid_no_write: data %0d done %0d valid-tag %0d want 0 0 0",
                           wr_cnt - w0, done_cnt - d0, vtag_cnt - t0);
      end
      n_cmp++;
      if ({miss_ready, mem_req_valid, lru_fill_en} !== 3'b100) begin
         n_err++; $display("FAIL rst_mid_idle: got %b want 100", {miss_ready, mem_req_valid, lru_fill_en});
      end
      run_fill(22'h0ABCD, 4'd5, 2'd1, 0, 0, 32'h8888_0003, 1'b0, '0, '0, st);
      n_cmp++;
      if (wr_line !== exp_line(32'h8888_0003) || done_cyc !== st + 8) begin
         n_err++; $display("FAIL rst_mid_refill: line %h cyc %0d want %h cyc 8", wr_line, done_cyc - st,
                           exp_line(32'h8888_0003));
      end
   endtask

   task automatic test_boundaries();
      int st;
      run_fill(22'h3FFFFF, 4'd15, 2'd3, 0, 0, 32'hFFFF_FFFF, 1'b0, '0, '0, st);
      n_cmp++;
      if (req_addr !== 32'hFFFFFFC0) begin
         n_err++; $display("FAIL bound_addr: got %h want ffffffc0", req_addr);
      end
      n_cmp++;
      if ({inv_way, inv_set, wr_way, wr_set, wr_tag_way, wr_tag_set, done_way} !==
          {2'd3, 4'd15, 2'd3, 4'd15, 2'd3, 4'd15, 2'd3} || wr_tag !== 22'h3FFFFF) begin
         n_err++; $display("FAIL bound_indices: inv %0d/%0d wr %0d/%0d tag %0d/%0d done %0d tag %h",
                           inv_way, inv_set, wr_way, wr_set, wr_tag_way, wr_tag_set, done_way, wr_tag);
      end
      n_cmp++;
      if (wr_line !== exp_line(32'hFFFF_FFFF)) begin
         n_err++; $display("FAIL bound_line: got %h want %h", wr_line, exp_line(32'hFFFF_FFFF));
      end
      run_fill(22'h00001, 4'd0, 2'd0, 0, 0, 32'h0246_8ACE, 1'b0, '0, '0, st);
      n_cmp++;
      if (wr_line !== exp_line(32'h0246_8ACE) || wr_cyc !== st + 8 || req_addr !== 32'h0000_0400) begin
         n_err++; $display("FAIL bound_wrap_next: line %h cyc %0d addr %h want %h cyc 8 addr 00000400",
                           wr_line, wr_cyc - st, req_addr, exp_line(32'h0246_8ACE));
      end
      n_cmp++;
      if (zero_viol !== 0) begin
         n_err++; $display("FAIL gated_outputs: %0d cycles with nonzero payload while strobe low want 0", zero_viol);
      end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_backpressure();
      test_beat_gaps();
      test_back_to_back_busy();
      test_reset_mid_fill();
      test_boundaries();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
